operand_entry_fsm: RTL
======================

// Module: operand_entry_fsm
// PURPOSE
//  Upstream stage of the adder: turns debounced keypad events into two
//  binary operands and fires a one-cycle enable to the adder.
//  Decimal digits are accumulated MSD-first into operand A, then operand B.
//  After the second ENTER it pulses enable and waits for the adder's
//  sum_state, then holds in SHOW until the next key.
// PARAMETERS
//  WIDTH       12     operand width, must match adder number1/number2
//  MAX_DIGITS  3      decimal digits accepted per operand (999 max, fits WIDTH)
//  KEY_ENTER   4'hA   key code that closes the current operand
//  KEY_CLEAR   4'hC   key code that aborts entry and zeroes both operands
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  reset        in   1      asynchronous, active-high reset
//  key_valid    in   1      one-cycle pulse, one key per high cycle
//  key_code     in   4      0-9 digit, KEY_ENTER, KEY_CLEAR, others ignored
//  sum_state    in   1      adder done flag (high cycle after enable)
//  number1      out  WIDTH  operand A to adder
//  number2      out  WIDTH  operand B to adder
//  enable       out  1      adder start, high exactly one cycle per add
//  entry_value  out  WIDTH  operand currently being typed (display feed)
//  digit_count  out  2      digits typed into current operand, 0..MAX_DIGITS
//  phase        out  3      state code below
//  result_valid out  1      high while in SHOW
// BEHAVIOUR
//  Reset: all outputs 0, phase=READ_A; async assert, takes effect mid-op.
//  States: READ_A=0, READ_B=1, ADD=2, WAIT_SUM=3, SHOW=4; others -> READ_A.
//  Digit d in READ_A/READ_B with digit_count<MAX_DIGITS:
//   operand <= operand*10 + d (WIDTH bits, no overflow possible), count+1.
//   Digit at count==MAX_DIGITS: ignored, no state change.
//  ENTER in READ_A, count>=1: -> READ_B, count<=0, number1 frozen.
//  ENTER in READ_B, count>=1: -> ADD. ENTER with count==0: ignored.
//  ADD: enable=1 this cycle only (decoded from state), -> WAIT_SUM next.
//  WAIT_SUM: stay until sum_state=1, then -> SHOW. enable stays 0.
//  SHOW: result_valid=1; number1/number2 held. Digit key: zero both
//   operands, load digit into A, count=1, -> READ_A. ENTER ignored.
//  CLEAR in any state: both operands 0, count 0, -> READ_A next cycle;
//   overrides a coincident sum_state in WAIT_SUM.
//  Codes B,D,E,F and key_valid=0 cycles: no effect.
//  entry_value = number1 in READ_A, number2 in READ_B, else number2.
//  Enter-to-enable latency: 1 cycle after the ENTER sample edge.
// TESTING
//  1,2,3,ENT,4,5,6,ENT -> number1=123(0x07B), number2=456(0x1C8),
//   enable one cycle, adder sum 579; phase 2->3->4, result_valid=1.
//  9,9,9,9,ENT -> 4th digit dropped, number1=999, digit_count stuck at 3.
//  ENT with no digits in READ_A and READ_B -> phase unchanged, no enable.
//  7,ENT,5,CLR -> number1=number2=0, phase=READ_A, no enable ever.
//  In SHOW press 8 -> number1=8, number2=0, count=1, phase=READ_A.
//  reset pulse in WAIT_SUM -> all outputs 0 same cycle, phase=READ_A;
//   key codes B/F in READ_A -> no change.

Source files
------------

// File: rtl/operand_entry_fsm_if.sv
// Keypad-to-adder bundle for the operand entry stage: key events and the adder
// done flag in, operands, adder start and display/status feeds out.
interface operand_entry_fsm_if #(
    parameter int WIDTH = 12
);
    // key_valid is a one-cycle strobe carrying one key_code per high cycle;
    // enable is a one-cycle start strobe to the adder, and sum_state is the
    // adder's reply, sampled only while waiting for it.
    logic             key_valid;
    logic [3:0]       key_code;
    logic             sum_state;
    logic [WIDTH-1:0] number1;
    logic [WIDTH-1:0] number2;
    logic             enable;
    logic [WIDTH-1:0] entry_value;
    logic [1:0]       digit_count;
    logic [2:0]       phase;
    logic             result_valid;

    modport master (
        output key_valid, key_code, sum_state,
        input  number1, number2, enable, entry_value, digit_count, phase, result_valid
    );

    modport slave (
        input  key_valid, key_code, sum_state,
        output number1, number2, enable, entry_value, digit_count, phase, result_valid
    );
endinterface

// File: rtl/operand_entry_fsm.sv
// Keypad operand entry: accumulates decimal digits MSD-first into two operands,
// starts the adder with a one-cycle enable and holds the result view until the next key.
module operand_entry_fsm #(
    parameter int         WIDTH      = 12,
    parameter int         MAX_DIGITS = 3,
    parameter logic [3:0] KEY_ENTER  = 4'hA,
    parameter logic [3:0] KEY_CLEAR  = 4'hC
) (
    input  logic              clk,
    input  logic              reset,
    operand_entry_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        READ_A   = 3'd0,
        READ_B   = 3'd1,
        ADD      = 3'd2,
        WAIT_SUM = 3'd3,
        SHOW     = 3'd4
    } state_e;

    localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] num1_q, num1_d;
    logic [WIDTH-1:0] num2_q, num2_d;
    logic [1:0]       cnt_q, cnt_d;

    logic             is_digit;
    logic             is_enter;
    logic             is_clear;
    logic             has_room;
    logic [WIDTH-1:0] digit_w;

    assign digit_w  = WIDTH'(bus.key_code);
    assign is_digit = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_enter = bus.key_valid && (bus.key_code == KEY_ENTER);
    assign is_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);
    assign has_room = (cnt_q < MAX_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= READ_A;
            num1_q  <= '0;
            num2_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            num1_q  <= num1_d;
            num2_q  <= num2_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num1_d  = num1_q;
        num2_d  = num2_q;
        cnt_d   = cnt_q;

        // CLEAR wins over everything, including a sum_state arriving the same cycle.
        if (is_clear) begin
            state_d = READ_A;
            num1_d  = '0;
            num2_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                READ_A: begin
                    if (is_digit && has_room) begin
                        num1_d = (num1_q << 3) + (num1_q << 1) + digit_w;
                        cnt_d  = cnt_q + 2'd1;
                    end else if (is_enter && (cnt_q != 2'd0)) begin
                        state_d = READ_B;
                        cnt_d   = '0;
                    end
                end
                READ_B: begin
                    if (is_digit && has_room) begin
                        num2_d = (num2_q << 3) + (num2_q << 1) + digit_w;
                        cnt_d  = cnt_q + 2'd1;
                    end else if (is_enter && (cnt_q != 2'd0)) begin
                        state_d = ADD;
                    end
                end
                ADD: begin
                    state_d = WAIT_SUM;
                end
                WAIT_SUM: begin
                    if (bus.sum_state) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    // A digit here starts a fresh calculation with that digit as A's MSD.
                    if (is_digit) begin
                        state_d = READ_A;
                        num1_d  = digit_w;
                        num2_d  = '0;
                        cnt_d   = 2'd1;
                    end
                end
                default: begin
                    state_d = READ_A;
                end
            endcase
        end
    end

    assign bus.number1      = num1_q;
    assign bus.number2      = num2_q;
    assign bus.enable       = (state_q == ADD);
    assign bus.result_valid = (state_q == SHOW);
    assign bus.entry_value  = (state_q == READ_A) ? num1_q : num2_q;
    assign bus.digit_count  = cnt_q;
    assign bus.phase        = state_q;

endmodule
